// File: rtl/one_d_idct_kernel_pkg.sv
// Shared constants for the forward and inverse 1-D DCT kernels: cos(k*pi/16)*1024, the
// output scaling shift and the per-output coefficient signs of the inverse butterfly.
package one_d_idct_kernel_pkg;

    localparam int INPUTWIDTH  = 16;
    localparam int OUTPUTWIDTH = 16;
    localparam int SHIFT       = 11;

    typedef logic signed [15:0] coef_t;

    localparam coef_t COS1 = 16'sd1004;
    localparam coef_t COS2 = 16'sd946;
    localparam coef_t COS3 = 16'sd851;
    localparam coef_t COS4 = 16'sd724;
    localparam coef_t COS5 = 16'sd569;
    localparam coef_t COS6 = 16'sd392;
    localparam coef_t COS7 = 16'sd200;

    // Row n gives E_n from X0,X2,X4,X6 and O_n from X1,X3,X5,X7.
    localparam coef_t EVEN_COEF [4][4] = '{
        '{COS4,  COS2,  COS4,  COS6},
        '{COS4,  COS6, -COS4, -COS2},
        '{COS4, -COS6, -COS4,  COS2},
        '{COS4, -COS2,  COS4, -COS6}
    };
    localparam coef_t ODD_COEF [4][4] = '{
        '{COS1,  COS3,  COS5,  COS7},
        '{COS3, -COS7, -COS1, -COS5},
        '{COS5, -COS1,  COS7,  COS3},
        '{COS7, -COS5,  COS3, -COS1}
    };

endpackage

// File: rtl/one_d_idct_kernel_sat_shift.sv
// Arithmetic right shift by SHIFT (floor) followed by saturation to the signed DATA_W range.
module idct_sat_shift
    import one_d_idct_kernel_pkg::*;
#(
    parameter int DATA_W = INPUTWIDTH,
    parameter int ACC_W  = 36
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] y
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0] sh;

    always_comb begin
        sh = acc >>> SHIFT;
        if (sh > MAX_V) begin
            y = MAX_V[DATA_W-1:0];
        end else if (sh < MIN_V) begin
            y = MIN_V[DATA_W-1:0];
        end else begin
            y = sh[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/one_d_idct_kernel.sv
// 8-point 1-D inverse DCT, six register stages with a valid/ready handshake; a result
// held at the output and not taken stalls every stage.
module one_d_idct_kernel
    import one_d_idct_kernel_pkg::*;
#(
    parameter int DATA_W = INPUTWIDTH,
    parameter int ACC_W  = 36
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] X_0,
    input  logic signed [DATA_W-1:0] X_1,
    input  logic signed [DATA_W-1:0] X_2,
    input  logic signed [DATA_W-1:0] X_3,
    input  logic signed [DATA_W-1:0] X_4,
    input  logic signed [DATA_W-1:0] X_5,
    input  logic signed [DATA_W-1:0] X_6,
    input  logic signed [DATA_W-1:0] X_7,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] Y_0,
    output logic signed [DATA_W-1:0] Y_1,
    output logic signed [DATA_W-1:0] Y_2,
    output logic signed [DATA_W-1:0] Y_3,
    output logic signed [DATA_W-1:0] Y_4,
    output logic signed [DATA_W-1:0] Y_5,
    output logic signed [DATA_W-1:0] Y_6,
    output logic signed [DATA_W-1:0] Y_7
);

    logic [5:0]                v_q;
    logic signed [DATA_W-1:0]  x_q  [8];
    logic signed [ACC_W-1:0]   p_d  [2][4][4];
    logic signed [ACC_W-1:0]   p_q  [2][4][4];
    logic signed [ACC_W-1:0]   s3_d [2][4][2];
    logic signed [ACC_W-1:0]   s3_q [2][4][2];
    logic signed [ACC_W-1:0]   eo_d [2][4];
    logic signed [ACC_W-1:0]   eo_q [2][4];
    logic signed [ACC_W-1:0]   bf_d [8];
    logic signed [ACC_W-1:0]   bf_q [8];
    logic signed [DATA_W-1:0]  y_d  [8];
    logic signed [DATA_W-1:0]  y_q  [8];
    logic                      stall;

    assign stall     = v_q[5] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v_q[5];

    // Index h selects even (X0,X2,..) or odd (X1,X3,..) inputs; everything is widened first.
    always_comb begin
        for (int h = 0; h < 2; h++) begin
            for (int n = 0; n < 4; n++) begin
                for (int k = 0; k < 4; k++) begin
                    p_d[h][n][k] = ACC_W'(x_q[2*k+h]) *
                                   ACC_W'((h == 0) ? EVEN_COEF[n][k] : ODD_COEF[n][k]);
                end
                s3_d[h][n][0] = p_q[h][n][0] + p_q[h][n][1];
                s3_d[h][n][1] = p_q[h][n][2] + p_q[h][n][3];
                eo_d[h][n]    = s3_q[h][n][0] + s3_q[h][n][1];
            end
        end
        for (int n = 0; n < 4; n++) begin
            bf_d[n]   = eo_q[0][n] + eo_q[1][n];
            bf_d[7-n] = eo_q[0][n] - eo_q[1][n];
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_sat
        idct_sat_shift #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_sat (
            .acc (bf_q[i]),
            .y   (y_d[i])
        );
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            v_q  <= '0;
            x_q  <= '{default: '0};
            p_q  <= '{default: '0};
            s3_q <= '{default: '0};
            eo_q <= '{default: '0};
            bf_q <= '{default: '0};
            y_q  <= '{default: '0};
        end else if (!stall) begin
            v_q  <= {v_q[4:0], in_valid};
            x_q  <= '{X_0, X_1, X_2, X_3, X_4, X_5, X_6, X_7};
            p_q  <= p_d;
            s3_q <= s3_d;
            eo_q <= eo_d;
            bf_q <= bf_d;
            y_q  <= y_d;
        end
    end

    assign Y_0 = y_q[0];
    assign Y_1 = y_q[1];
    assign Y_2 = y_q[2];
    assign Y_3 = y_q[3];
    assign Y_4 = y_q[4];
    assign Y_5 = y_q[5];
    assign Y_6 = y_q[6];
    assign Y_7 = y_q[7];

endmodule

// File: tb/tb_one_d_idct_kernel.sv
// Directed and scoreboarded checks for one_d_idct_kernel: impulses, truncation, saturation,
// streaming, round trip, backpressure and mid-stream reset.
module tb_one_d_idct_kernel;

    typedef logic [7:0][15:0] vec_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    vec_t        x_in = '0;
    logic [15:0] y [8];
    vec_t        y_bus;

    int n_total = 0;
    int n_bad   = 0;
    int n_acc   = 0;
    int n_cons  = 0;
    vec_t q_exp [$];
    vec_t last_y;
    vec_t y_prev;
    logic stall_prev = 1'b0;

    always #5 Clk = ~Clk;

    assign y_bus = {y[7], y[6], y[5], y[4], y[3], y[2], y[1], y[0]};

    one_d_idct_kernel #(
        .DATA_W (16),
        .ACC_W  (36)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_0       (x_in[0]),
        .X_1       (x_in[1]),
        .X_2       (x_in[2]),
        .X_3       (x_in[3]),
        .X_4       (x_in[4]),
        .X_5       (x_in[5]),
        .X_6       (x_in[6]),
        .X_7       (x_in[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y_0       (y[0]),
        .Y_1       (y[1]),
        .Y_2       (y[2]),
        .Y_3       (y[3]),
        .Y_4       (y[4]),
        .Y_5       (y[5]),
        .Y_6       (y[6]),
        .Y_7       (y[7])
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic vec_t vec8(input int v0, v1, v2, v3, v4, v5, v6, v7);
        vec_t r;
        r[0] = 16'(v0); r[1] = 16'(v1); r[2] = 16'(v2); r[3] = 16'(v3);
        r[4] = 16'(v4); r[5] = 16'(v5); r[6] = 16'(v6); r[7] = 16'(v7);
        return r;
    endfunction

    // Unshifted E+-O sums, written straight from the defining equations.
    function automatic void idct_acc(input vec_t x, output longint acc [8]);
        longint a = 724, b = 1004, c = 946, d = 851, e = 569, f = 392, g = 200;
        longint x0, x1, x2, x3, x4, x5, x6, x7;
        longint e0, e1, e2, e3, o0, o1, o2, o3;
        x0 = $signed(x[0]); x1 = $signed(x[1]); x2 = $signed(x[2]); x3 = $signed(x[3]);
        x4 = $signed(x[4]); x5 = $signed(x[5]); x6 = $signed(x[6]); x7 = $signed(x[7]);
        e0 = a*x0 + c*x2 + a*x4 + f*x6;
        e1 = a*x0 + f*x2 - a*x4 - c*x6;
        e2 = a*x0 - f*x2 - a*x4 + c*x6;
        e3 = a*x0 - c*x2 + a*x4 - f*x6;
        o0 = b*x1 + d*x3 + e*x5 + g*x7;
        o1 = d*x1 - g*x3 - b*x5 - e*x7;
        o2 = e*x1 - b*x3 + g*x5 + d*x7;
        o3 = g*x1 - e*x3 + d*x5 - b*x7;
        acc[0] = e0 + o0; acc[7] = e0 - o0;
        acc[1] = e1 + o1; acc[6] = e1 - o1;
        acc[2] = e2 + o2; acc[5] = e2 - o2;
        acc[3] = e3 + o3; acc[4] = e3 - o3;
    endfunction

    function automatic vec_t idct_ref(input vec_t x);
        longint acc [8];
        longint s;
        vec_t   r;
        idct_acc(x, acc);
        for (int i = 0; i < 8; i++) begin
            s = acc[i] >>> 11;
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            r[i] = 16'(s);
        end
        return r;
    endfunction

    // Forward transform uses the transpose of the inverse matrix; rounds to nearest.
    function automatic vec_t fwd(input vec_t s);
        longint col [8];
        longint sum;
        vec_t   u;
        vec_t   r;
        for (int k = 0; k < 8; k++) begin
            u = '0;
            u[k] = 16'd1;
            idct_acc(u, col);
            sum = 0;
            for (int n = 0; n < 8; n++) sum += col[n] * longint'($signed(s[n]));
            r[k] = 16'((sum + 1024) >>> 11);
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge Clk);
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (stall_prev) begin
            check("stall_hold_valid", out_valid, 1'b1);
            check("stall_hold_y", y_bus, y_prev);
        end
        if (out_valid && out_ready) begin
            check("out_expected", 128'(q_exp.size() != 0), 1'b1);
            if (q_exp.size() != 0) check("result", y_bus, q_exp.pop_front());
            last_y = y_bus;
            n_cons++;
        end
        if (in_valid && in_ready) begin
            q_exp.push_back(idct_ref(x_in));
            n_acc++;
        end
        stall_prev = out_valid && !out_ready;
        y_prev     = y_bus;
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vector(input vec_t x, output int lat);
        int a0 = n_acc;
        int c0 = n_cons;
        lat = 0;
        x_in = x;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && n_acc == a0; i++) tick();
        check("accept_timeout", 128'(n_acc != a0), 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 50 && n_cons == c0; i++) begin
            tick();
            lat++;
        end
        check("output_timeout", 128'(n_cons != c0), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   lat;
        int   target;
        vec_t s;
        logic ok;
        logic signed [7:0] rb;
        longint err;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_y", y_bus, '0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        out_ready = 1'b1;

        run_vector(vec8(2048, 0, 0, 0, 0, 0, 0, 0), lat);
        check("dc_latency", lat, 6);
        check("dc_value", last_y, vec8(724, 724, 724, 724, 724, 724, 724, 724));

        run_vector(vec8(0, 2048, 0, 0, 0, 0, 0, 0), lat);
        check("h1_value", last_y, vec8(1004, 851, 569, 200, -200, -569, -851, -1004));

        run_vector(vec8(-1, 0, 0, 0, 0, 0, 0, 0), lat);
        check("neg_trunc", last_y, vec8(-1, -1, -1, -1, -1, -1, -1, -1));

        run_vector(vec8(32767, 0, 32767, 0, 32767, 0, 32767, 0), lat);
        check("sat_pos", last_y, vec8(32767, -8864, 8863, 1759, 1759, 8863, -8864, 32767));

        run_vector(vec8(-32768, 0, -32768, 0, -32768, 0, -32768, 0), lat);
        check("sat_neg", last_y,
              vec8(-32768, 8864, -8864, -1760, -1760, -8864, 8864, -32768));

        // Back-to-back stream at full rate
        target = n_cons + 20;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            x_in = vec8($urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && n_cons < target; i++) tick();
        check("b2b_count", n_cons, target);
        check("b2b_drained", q_exp.size(), 0);

        // Round trip of 8-bit samples through the forward model
        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < 8; n++) begin
                rb = 8'($urandom);
                s[n] = 16'(rb);
            end
            run_vector(fwd(s), lat);
            ok = 1'b1;
            for (int n = 0; n < 8; n++) begin
                err = longint'($signed(last_y[n])) - longint'($signed(s[n]));
                if (err > 2 || err < -2) ok = 1'b0;
            end
            check("roundtrip_within_2", ok, 1'b1);
        end

        // Random backpressure and bubbles
        in_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int a0 = n_acc;
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                x_in = vec8($urandom, $urandom, $urandom, $urandom,
                            $urandom, $urandom, $urandom, $urandom);
            end
            out_ready = ($urandom_range(0, 9) >= 3);
            tick();
            if (n_acc != a0) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("bp_count", n_cons, n_acc);
        check("bp_drained", q_exp.size(), 0);

        // Reset with four vectors in flight
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x_in = vec8(1000 + i, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        in_valid = 1'b0;
        #2;
        Rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_y", y_bus, '0);
        q_exp.delete();
        stall_prev = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        target = n_cons;
        for (int i = 0; i < 12; i++) tick();
        check("midrst_no_ghosts", n_cons, target);

        run_vector(vec8(2048, 0, 0, 0, 0, 0, 0, 0), lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_value", last_y, vec8(724, 724, 724, 724, 724, 724, 724, 724));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/one_d_idct_kernel.md
# one_d_idct_kernel

8-point 1-D inverse DCT pipeline: the inverse of the forward 1-D DCT kernel, using the same cosine constants (cos(kπ/16)·1024) and the same >>>11 output scaling, so that forward→inverse round-trips a vector to within ±2 LSB. It sits on the decode side of the 2-D DCT datapath. One instance processes rows and a second processes columns after the transpose buffer. Unlike the CNT-gated forward kernel, it uses a valid/ready handshake with full-pipeline stall.

## Interface
- DATA_W, 16, signed width of X_* inputs and Y_* outputs (tie to `INPUTWIDTH/`OUTPUTWIDTH at instantiation)
- ACC_W, 36, internal signed accumulator width; must be ≥ 2·DATA_W+4

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  X_0..X_7 hold a coefficient vector
- in_ready  out  1  kernel accepts a vector this cycle
- X_0..X_7  in  DATA_W each  signed DCT coefficients, X_0 = DC
- out_valid  out  1  Y_0..Y_7 hold a result
- out_ready  in  1  downstream accepts result
- Y_0..Y_7  out  DATA_W each  signed reconstructed samples

## Operation
- Constants: a=724 (cos4), b=1004 (cos1), c=946 (cos2), d=851 (cos3), e=569 (cos5), f=392 (cos6), g=200 (cos7). All are 16-bit signed.
- Even part:
  - E0=aX0+cX2+aX4+fX6
  - E1=aX0+fX2−aX4−cX6
  - E2=aX0−fX2−aX4+cX6
  - E3=aX0−cX2+aX4−fX6
- Odd part:
  - O0=bX1+dX3+eX5+gX7
  - O1=dX1−gX3−bX5−eX7
  - O2=eX1−bX3+gX5+dX7
  - O3=gX1−eX3+dX5−bX7
- Butterfly: Yn = (En+On)>>>11 and Y(7−n) = (En−On)>>>11, for n=0..3.
- Arithmetic shift truncates toward −∞; no rounding, which matches the forward kernel.
- After the shift, each result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
- All intermediate values are sign-extended to ACC_W, so no internal overflow is possible.
- Pipeline stages, each a register bank plus a valid bit v1..v6:
  - S1: capture X_*.
  - S2: form 32 products.
  - S3: pairwise sums.
  - S4: E0..E3 and O0..O3.
  - S5: butterfly, 8 sums.
  - S6: shift + saturate into Y_* output registers; v6 = out_valid.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - On stall, every stage register and valid bit holds.
  - Otherwise all stages advance and v1 ← in_valid.
- A vector is accepted on a cycle where in_valid & in_ready.
- A result is consumed on a cycle where out_valid & out_ready.
- Bubbles (in_valid=0) propagate as cleared valid bits. They do not stall, and there is no bubble collapsing.
- Y_* hold their value while out_valid=0 after a transfer. Consumers must qualify Y_* with out_valid.

## Timing
- Reset values: v1..v6=0, out_valid=0, Y_0..Y_7=0, all datapath registers 0. in_ready=1 while out_ready is anything, because out_valid=0.
- Latency: a vector accepted at edge t appears with out_valid=1 after edge t+5, i.e. 6 register stages.
- Throughput: 1 vector/cycle when out_ready is held high.
- Stall: Y_* and out_valid stay stable until consumed. in_ready drops in the same cycle, so no input is lost or duplicated.
- Simultaneous in_valid and stall: the input is not accepted; the source must hold it.
- Rst mid-stream: all in-flight vectors are discarded immediately (asynchronous). The first out_valid after Rst deasserts is ≥6 cycles after the first accepted vector.

## Structure
- Shared define/package holds:
  - cosine constants COS1..COS7
  - SHIFT=11
  - DATA_W defaults (`INPUTWIDTH, `OUTPUTWIDTH)
- The forward kernel reuses the same constants.
- One natural sub-module: idct_sat_shift (ACC_W in → DATA_W out, >>>11 plus saturation), instantiated 8×. The rest stays flat in one_d_idct_kernel.

## Test plan
- DC impulse: X0=2048, others 0 → all Y_n=724, out_valid exactly 6 cycles after acceptance.
- First-harmonic impulse: X1=2048, others 0 → Y=[1004, 851, 569, 200, −200, −569, −851, −1004].
- Negative truncation: X0=−1, others 0 → all Y_n=−1. Saturation: X0=X2=X4=X6=32767, others 0 → Y0=32767 (unsaturated value 44574).
- Back-to-back: 20 random vectors with in_valid=1 and out_ready=1 → 20 results in order, each matching a bit-exact reference model; then a forward-kernel→IDCT round trip of random 8-bit samples stays within ±2.
- Backpressure: random out_ready with ~30% low, random in_valid → no lost or duplicated vectors. Y_* stay stable while out_valid & ~out_ready, and in_ready = ~(out_valid & ~out_ready) every cycle.
- Reset mid-operation: assert Rst with 4 vectors in flight → out_valid=0 and Y_*=0 immediately; none of the 4 results ever appears; a post-reset vector returns correctly after 6 cycles.
